// File: rtl/three_to_eight_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : three_to_eight_decoder_if
// Brief    : Function-select bus between the instruction field and the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface three_to_eight_decoder_if;
    logic       load;
    logic [2:0] fctn_code;
    logic       enable;
    logic [2:0] fctn_latched;
    logic [7:0] op_onehot;
    logic       op_changed;
    logic       op_valid;

    modport master (
        output load, fctn_code, enable,
        input  fctn_latched, op_onehot, op_changed, op_valid
    );

    modport slave (
        input  load, fctn_code, enable,
        output fctn_latched, op_onehot, op_changed, op_valid
    );
endinterface
`default_nettype wire

// File: rtl/three_to_eight_decoder.sv
`default_nettype none
// ============================================================================
// Module   : three_to_eight_decoder
// Brief    : Latches a 3-bit ALU function code; drives a gated MSB-first one-hot.
// Revision : 1.0 - initial release
// ============================================================================
module three_to_eight_decoder #(
    parameter logic [2:0] RESET_CODE = 3'b111
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    three_to_eight_decoder_if.slave bus
);

    localparam logic [7:0] C_MSB_SEL = 8'b1000_0000;

    logic [2:0] r_fctn;
    logic       r_changed;
    logic [7:0] w_onehot;
    logic       w_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fctn    <= RESET_CODE;
            r_changed <= 1'b0;
        end else if (bus.load) begin
            r_fctn    <= bus.fctn_code;
            r_changed <= (bus.fctn_code != r_fctn);
        end else begin
            r_changed <= 1'b0;
        end
    end

    // Code 0 selects bit 7, so shift the MSB down rather than bit 0 up.
    always_comb begin
        w_onehot = 8'h00;
        if (bus.enable) begin
            w_onehot = C_MSB_SEL >> r_fctn;
        end
    end

    assign w_valid = (w_onehot != 8'h00) && ((w_onehot & (w_onehot - 8'd1)) == 8'h00);

    assign bus.fctn_latched = r_fctn;
    assign bus.op_onehot    = w_onehot;
    assign bus.op_changed   = r_changed;
    assign bus.op_valid     = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_three_to_eight_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_three_to_eight_decoder
// Brief    : Scoreboard bench with a behavioural model of the function decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_three_to_eight_decoder;

    typedef struct {
        logic [2:0] latched;
        logic [7:0] onehot;
        logic       changed;
        logic       valid;
        string      tag;
    } exp_t;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    // Reference state
    int   m_code;
    bit   m_changed;

    three_to_eight_decoder_if bus ();

    three_to_eight_decoder #(.RESET_CODE(3'b111)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_onehot(input int code, input bit en);
        int v;
        v = en ? (1 << (7 - code)) : 0;
        return v[7:0];
    endfunction

    // Inputs change just after a rising edge; the monitor samples on the
    // following falling edge, before the next rising edge can capture them.
    task automatic step(input bit rn, input bit ld, input int code, input bit en, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rn;
        bus.load      = ld;
        bus.fctn_code = code[2:0];
        bus.enable    = en;
        if (!rn) begin
            m_code    = 7;
            m_changed = 0;
        end
        e.latched = m_code[2:0];
        e.onehot  = ref_onehot(m_code, en);
        e.changed = m_changed;
        e.valid   = en;
        e.tag     = tag;
        sb.push_back(e);
        if (rn) begin
            if (ld) begin
                m_changed = (code != m_code);
                m_code    = code;
            end else begin
                m_changed = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (bus.fctn_latched !== e.latched || bus.op_onehot !== e.onehot ||
                bus.op_changed !== e.changed || bus.op_valid !== e.valid) begin
                fails++;
                $display("FAIL %s: got latched=%b onehot=%b changed=%b valid=%b, expected latched=%b onehot=%b changed=%b valid=%b",
                         e.tag, bus.fctn_latched, bus.op_onehot, bus.op_changed, bus.op_valid,
                         e.latched, e.onehot, e.changed, e.valid);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        m_code = 7;
        m_changed = 0;
        reset_n = 1'b0;
        bus.load = 1'b0;
        bus.fctn_code = 3'b000;
        bus.enable = 1'b1;

        step(0, 0, 0, 1, "reset");
        step(0, 1, 3, 1, "reset_overrides_load");

        for (int c = 0; c < 8; c++) step(1, 1, c, 1, "sweep");
        step(1, 0, 0, 1, "sweep_last");

        for (int i = 0; i < 4; i++) step(1, 0, $urandom_range(0, 7), 1, "hold");

        step(1, 1, 4, 1, "gate_load");
        step(1, 0, 0, 1, "gate_on");
        step(1, 0, 0, 0, "gate_off");
        step(1, 0, 0, 1, "gate_restore");

        step(1, 1, 2, 1, "same_load_a");
        step(1, 1, 2, 1, "same_load_b");
        step(1, 1, 2, 1, "same_load_c");
        step(1, 1, 3, 1, "diff_load");
        step(1, 0, 0, 1, "diff_pulse");
        step(1, 0, 0, 1, "diff_pulse_end");

        step(1, 1, 0, 1, "mid_load_add");
        step(1, 0, 0, 1, "mid_hold_add");
        step(0, 0, 0, 1, "mid_async_reset");
        step(1, 1, 6, 1, "mid_release_load");
        step(1, 0, 0, 1, "mid_shiftl");

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 7), ($urandom_range(0, 3) != 0), "random");
        end
        step(1, 0, 0, 1, "final");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
